// File: rtl/rojobot_pkg.sv
// Shared codes for the rojobot drive model: wheel actions, motion codes,
// compass headings and the heading-to-unit-step table.
package rojobot_pkg;

    typedef enum logic [1:0] {
        WhlIdle,
        WhlFwd,
        WhlRev
    } wheel_e;

    typedef enum logic [2:0] {
        MotStop  = 3'd0,
        MotFwd   = 3'd1,
        MotRev   = 3'd2,
        MotTurnL = 3'd3,
        MotTurnR = 3'd4,
        MotSpinL = 3'd5,
        MotSpinR = 3'd6
    } motion_e;

    typedef enum logic [2:0] {
        HdgN, HdgNE, HdgE, HdgSE, HdgS, HdgSW, HdgW, HdgNW
    } heading_e;

    typedef struct packed {
        logic signed [1:0] dx;
        logic signed [1:0] dy;
    } step_t;

    function automatic wheel_e wheel_act(input logic fwd, input logic rev);
        case ({fwd, rev})
            2'b10:   return WhlFwd;
            2'b01:   return WhlRev;
            default: return WhlIdle;
        endcase
    endfunction

    // +y is north, +x is east.
    function automatic step_t hdg_step(input logic [2:0] hdg);
        case (hdg)
            HdgN:    return '{dx: 2'sb00, dy: 2'sb01};
            HdgNE:   return '{dx: 2'sb01, dy: 2'sb01};
            HdgE:    return '{dx: 2'sb01, dy: 2'sb00};
            HdgSE:   return '{dx: 2'sb01, dy: 2'sb11};
            HdgS:    return '{dx: 2'sb00, dy: 2'sb11};
            HdgSW:   return '{dx: 2'sb11, dy: 2'sb11};
            HdgW:    return '{dx: 2'sb11, dy: 2'sb00};
            default: return '{dx: 2'sb11, dy: 2'sb01};
        endcase
    endfunction

endpackage

// File: rtl/rojobot_tick_gen.sv
// Rate divider: emits a one-cycle tick every top+1 clocks; a change of
// rate_sel restarts the count.
module rojobot_tick_gen
    import rojobot_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY_HZ = 100000000,
    parameter int unsigned RATE0_HZ         = 1,
    parameter int unsigned RATE1_HZ         = 5,
    parameter int unsigned RATE2_HZ         = 10,
    parameter int unsigned SIMULATE         = 0,
    parameter int unsigned SIM_CNT0         = 1,
    parameter int unsigned SIM_CNT1         = 5,
    parameter int unsigned SIM_CNT2         = 10,
    parameter int unsigned CNTR_WIDTH       = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] rate_sel,
    output logic       tick
);

    localparam logic [CNTR_WIDTH-1:0] Top0 =
        CNTR_WIDTH'(SIMULATE != 0 ? SIM_CNT0 : CLK_FREQUENCY_HZ / RATE0_HZ - 1);
    localparam logic [CNTR_WIDTH-1:0] Top1 =
        CNTR_WIDTH'(SIMULATE != 0 ? SIM_CNT1 : CLK_FREQUENCY_HZ / RATE1_HZ - 1);
    localparam logic [CNTR_WIDTH-1:0] Top2 =
        CNTR_WIDTH'(SIMULATE != 0 ? SIM_CNT2 : CLK_FREQUENCY_HZ / RATE2_HZ - 1);

    logic [CNTR_WIDTH-1:0] cnt_q, cnt_d, top;
    logic [1:0]            rate_q, rate_d;
    logic                  tick_q, tick_d;

    always_comb begin
        case (rate_sel)
            2'd0:    top = Top0;
            2'd1:    top = Top1;
            default: top = Top2;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q + CNTR_WIDTH'(1);
        tick_d = 1'b0;
        rate_d = rate_sel;
        if (rate_sel != rate_q) begin
            cnt_d = '0;
        end else if (cnt_q == top) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            rate_q <= 2'd0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rate_q <= rate_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/rojobot_drive.sv
// Differential-drive robot model: on each tick, advances wheel counters,
// decodes motion, and updates heading and world location.
module rojobot_drive
    import rojobot_pkg::*;
#(
    parameter int unsigned CLK_FREQUENCY_HZ = 100000000,
    parameter int unsigned RATE0_HZ         = 1,
    parameter int unsigned RATE1_HZ         = 5,
    parameter int unsigned RATE2_HZ         = 10,
    parameter int unsigned SIMULATE         = 0,
    parameter int unsigned SIM_CNT0         = 1,
    parameter int unsigned SIM_CNT1         = 5,
    parameter int unsigned SIM_CNT2         = 10,
    parameter int unsigned POS_WIDTH        = 8,
    parameter int unsigned SATURATE         = 0,
    parameter int unsigned CNTR_WIDTH       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 left_fwd,
    input  logic                 left_rev,
    input  logic                 right_fwd,
    input  logic                 right_rev,
    input  logic [1:0]           rate_sel,
    output logic [POS_WIDTH-1:0] left_pos,
    output logic [POS_WIDTH-1:0] right_pos,
    output logic [2:0]           heading,
    output logic [POS_WIDTH-1:0] loc_x,
    output logic [POS_WIDTH-1:0] loc_y,
    output logic [2:0]           motion,
    output logic                 tick
);

    logic [POS_WIDTH-1:0] left_pos_q, left_pos_d, right_pos_q, right_pos_d;
    logic [POS_WIDTH-1:0] loc_x_q, loc_x_d, loc_y_q, loc_y_d;
    logic [POS_WIDTH-1:0] dx_ext, dy_ext;
    logic [2:0]           heading_q, heading_d, hdg_inc;
    motion_e              motion_q, motion_d, mot;
    wheel_e               l_act, r_act;
    step_t                stp;

    rojobot_tick_gen #(
        .CLK_FREQUENCY_HZ(CLK_FREQUENCY_HZ),
        .RATE0_HZ        (RATE0_HZ),
        .RATE1_HZ        (RATE1_HZ),
        .RATE2_HZ        (RATE2_HZ),
        .SIMULATE        (SIMULATE),
        .SIM_CNT0        (SIM_CNT0),
        .SIM_CNT1        (SIM_CNT1),
        .SIM_CNT2        (SIM_CNT2),
        .CNTR_WIDTH      (CNTR_WIDTH)
    ) u_tick_gen (
        .clk     (clk),
        .reset   (reset),
        .rate_sel(rate_sel),
        .tick    (tick)
    );

    function automatic logic [POS_WIDTH-1:0] wheel_next(input logic [POS_WIDTH-1:0] pos,
                                                        input wheel_e act);
        if (act == WhlFwd) begin
            if (SATURATE != 0 && pos == {POS_WIDTH{1'b1}}) return pos;
            return pos + POS_WIDTH'(1);
        end else if (act == WhlRev) begin
            if (SATURATE != 0 && pos == '0) return pos;
            return pos - POS_WIDTH'(1);
        end
        return pos;
    endfunction

    always_comb begin
        l_act = wheel_act(left_fwd, left_rev);
        r_act = wheel_act(right_fwd, right_rev);
        if (l_act == r_act) begin
            mot = (l_act == WhlFwd) ? MotFwd : (l_act == WhlRev) ? MotRev : MotStop;
        end else if (l_act == WhlRev && r_act == WhlFwd) begin
            mot = MotSpinL;
        end else if (l_act == WhlFwd && r_act == WhlRev) begin
            mot = MotSpinR;
        end else if (r_act == WhlFwd || l_act == WhlRev) begin
            mot = MotTurnL;
        end else begin
            mot = MotTurnR;
        end
    end

    always_comb begin
        case (mot)
            MotTurnR: hdg_inc = 3'd1;
            MotTurnL: hdg_inc = 3'd7;
            MotSpinR: hdg_inc = 3'd2;
            MotSpinL: hdg_inc = 3'd6;
            default:  hdg_inc = 3'd0;
        endcase
    end

    // Translation uses the heading held before this tick's rotation.
    always_comb begin
        stp    = hdg_step(heading_q);
        dx_ext = {{(POS_WIDTH-2){stp.dx[1]}}, stp.dx};
        dy_ext = {{(POS_WIDTH-2){stp.dy[1]}}, stp.dy};
    end

    always_comb begin
        left_pos_d  = left_pos_q;
        right_pos_d = right_pos_q;
        heading_d   = heading_q;
        loc_x_d     = loc_x_q;
        loc_y_d     = loc_y_q;
        motion_d    = motion_q;
        if (tick) begin
            left_pos_d  = wheel_next(left_pos_q, l_act);
            right_pos_d = wheel_next(right_pos_q, r_act);
            heading_d   = heading_q + hdg_inc;
            motion_d    = mot;
            if (mot == MotFwd) begin
                loc_x_d = loc_x_q + dx_ext;
                loc_y_d = loc_y_q + dy_ext;
            end else if (mot == MotRev) begin
                loc_x_d = loc_x_q - dx_ext;
                loc_y_d = loc_y_q - dy_ext;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            left_pos_q  <= '0;
            right_pos_q <= '0;
            heading_q   <= 3'd0;
            loc_x_q     <= '0;
            loc_y_q     <= '0;
            motion_q    <= MotStop;
        end else begin
            left_pos_q  <= left_pos_d;
            right_pos_q <= right_pos_d;
            heading_q   <= heading_d;
            loc_x_q     <= loc_x_d;
            loc_y_q     <= loc_y_d;
            motion_q    <= motion_d;
        end
    end

    assign left_pos  = left_pos_q;
    assign right_pos = right_pos_q;
    assign heading   = heading_q;
    assign loc_x     = loc_x_q;
    assign loc_y     = loc_y_q;
    assign motion    = motion_q;

endmodule

// File: tb/tb_rojobot_drive.sv
// Bench for rojobot_drive: wrapping and clamping instances driven together,
// checked every cycle against an arithmetic model of the robot.
module tb_rojobot_drive;

    logic       clk = 1'b0;
    logic       reset;
    logic       lf, lr, rf, rr;
    logic [1:0] rate_sel;

    logic [7:0] lp0, rp0, x0, y0, lp1, rp1, x1, y1;
    logic [2:0] hd0, mo0, hd1, mo1;
    logic       tk0, tk1;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int t_prev   = 0;
    int t_last   = 0;

    // Reference model state
    int m_tick, m_phase, m_prev_sel;
    int m_lp[2], m_rp[2];
    int m_hd, m_x, m_y, m_mo;

    always #5 clk = ~clk;

    rojobot_drive #(.SIMULATE(1), .SATURATE(0)) u_dut_wrap (
        .clk(clk), .reset(reset),
        .left_fwd(lf), .left_rev(lr), .right_fwd(rf), .right_rev(rr),
        .rate_sel(rate_sel),
        .left_pos(lp0), .right_pos(rp0), .heading(hd0),
        .loc_x(x0), .loc_y(y0), .motion(mo0), .tick(tk0)
    );

    rojobot_drive #(.SIMULATE(1), .SATURATE(1)) u_dut_sat (
        .clk(clk), .reset(reset),
        .left_fwd(lf), .left_rev(lr), .right_fwd(rf), .right_rev(rr),
        .rate_sel(rate_sel),
        .left_pos(lp1), .right_pos(rp1), .heading(hd1),
        .loc_x(x1), .loc_y(y1), .motion(mo1), .tick(tk1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cyc, obs, exp);
        end
    endtask

    function automatic int act(input logic f, input logic r);
        if (f && !r) return 1;
        if (r && !f) return -1;
        return 0;
    endfunction

    function automatic int mdx(input int h);
        if (h >= 1 && h <= 3) return 1;
        if (h >= 5) return -1;
        return 0;
    endfunction

    function automatic int mdy(input int h);
        if (h == 7 || h <= 1) return 1;
        if (h >= 3 && h <= 5) return -1;
        return 0;
    endfunction

    function automatic int top_of(input logic [1:0] s);
        return (s == 2'd0) ? 1 : (s == 2'd1) ? 5 : 10;
    endfunction

    // Rotation is left minus right wheel action; translation happens only
    // when both wheels agree.
    task automatic model_update();
        int la, ra, rot;
        la  = act(lf, lr);
        ra  = act(rf, rr);
        rot = la - ra;
        if (rot == 0) m_mo = (la == 1) ? 1 : (la == -1) ? 2 : 0;
        else if (rot == -1) m_mo = 3;
        else if (rot == 1)  m_mo = 4;
        else if (rot == -2) m_mo = 5;
        else                m_mo = 6;
        if (rot == 0) begin
            m_x = (m_x + la * mdx(m_hd) + 256) % 256;
            m_y = (m_y + la * mdy(m_hd) + 256) % 256;
        end
        m_hd     = (m_hd + rot + 8) % 8;
        m_lp[0]  = (m_lp[0] + la + 256) % 256;
        m_rp[0]  = (m_rp[0] + ra + 256) % 256;
        m_lp[1]  = (m_lp[1] + la < 0) ? 0 : (m_lp[1] + la > 255) ? 255 : m_lp[1] + la;
        m_rp[1]  = (m_rp[1] + ra < 0) ? 0 : (m_rp[1] + ra > 255) ? 255 : m_rp[1] + ra;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_tick = 0; m_phase = 0; m_prev_sel = 0;
            m_lp = '{0, 0}; m_rp = '{0, 0};
            m_hd = 0; m_x = 0; m_y = 0; m_mo = 0;
        end else begin
            if (m_tick != 0) model_update();
            if (int'(rate_sel) != m_prev_sel) begin
                m_phase = 0; m_tick = 0;
            end else if (m_phase == top_of(rate_sel)) begin
                m_phase = 0; m_tick = 1;
            end else begin
                m_phase++; m_tick = 0;
            end
            m_prev_sel = int'(rate_sel);
        end
        #1;
        if (tk0) begin
            t_prev = t_last;
            t_last = cyc;
        end
        check_eq("tick_wrap", 32'(tk0), 32'(m_tick));
        check_eq("tick_sat", 32'(tk1), 32'(m_tick));
        check_eq("lpos_wrap", 32'(lp0), 32'(m_lp[0]));
        check_eq("rpos_wrap", 32'(rp0), 32'(m_rp[0]));
        check_eq("lpos_sat", 32'(lp1), 32'(m_lp[1]));
        check_eq("rpos_sat", 32'(rp1), 32'(m_rp[1]));
        check_eq("heading", 32'(hd0), 32'(m_hd));
        check_eq("loc_x", 32'(x0), 32'(m_x));
        check_eq("loc_y", 32'(y0), 32'(m_y));
        check_eq("motion", 32'(mo0), 32'(m_mo));
    endtask

    task automatic set_btn(input logic a, input logic b, input logic c, input logic d);
        lf = a; lr = b; rf = c; rr = d;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
    endtask

    // Waits for n DUT ticks, then one more edge so the last update lands.
    task automatic wait_ticks(input int n);
        int seen = 0;
        for (int c = 0; c < 400 && seen < n; c++) begin
            step();
            if (tk0) seen++;
        end
        check_eq("tick_count", 32'(seen), 32'(n));
        step();
    endtask

    initial begin
        reset = 1'b1;
        rate_sel = 2'd0;
        set_btn(1, 1, 1, 1);
        repeat (20) step();
        check_eq("rst_lpos", 32'(lp0), 0);
        check_eq("rst_heading", 32'(hd0), 0);
        check_eq("rst_loc", 32'({x0, y0}), 0);
        check_eq("rst_motion", 32'(mo0), 0);

        // Both forward at rate 1
        rate_sel = 2'd1;
        set_btn(1, 0, 1, 0);
        do_reset();
        wait_ticks(3);
        check_eq("fwd_period", 32'(t_last - t_prev), 6);
        check_eq("fwd_lpos", 32'(lp0), 3);
        check_eq("fwd_rpos", 32'(rp0), 3);
        check_eq("fwd_loc_x", 32'(x0), 0);
        check_eq("fwd_loc_y", 32'(y0), 3);
        check_eq("fwd_motion", 32'(mo0), 1);

        // Spin right: heading 2,4,6,0
        set_btn(1, 0, 0, 1);
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            wait_ticks(1);
            check_eq("spin_heading", 32'(hd0), 32'((2 * k) % 8));
        end
        check_eq("spin_loc", 32'({x0, y0}), 0);
        check_eq("spin_lpos", 32'(lp0), 4);
        check_eq("spin_rpos_wrap", 32'(rp0), 252);
        check_eq("spin_rpos_sat", 32'(rp1), 0);
        check_eq("spin_motion", 32'(mo0), 6);

        // Single reverse wheel at the zero boundary
        set_btn(0, 0, 0, 1);
        do_reset();
        wait_ticks(1);
        check_eq("rrev_wrap", 32'(rp0), 255);
        check_eq("rrev_sat", 32'(rp1), 0);
        check_eq("rrev_heading", 32'(hd0), 1);

        set_btn(0, 1, 0, 1);
        do_reset();
        wait_ticks(1);
        check_eq("rev_loc_y", 32'(y0), 255);
        check_eq("rev_loc_x", 32'(x0), 0);

        // Diagonal travel at NE
        set_btn(1, 0, 0, 0);
        do_reset();
        wait_ticks(1);
        check_eq("ne_heading", 32'(hd0), 1);
        set_btn(1, 0, 1, 0);
        wait_ticks(2);
        check_eq("ne_loc_x", 32'(x0), 2);
        check_eq("ne_loc_y", 32'(y0), 2);

        // Rate change at count 3 restarts the divider
        set_btn(0, 0, 0, 0);
        rate_sel = 2'd1;
        do_reset();
        for (int c = 0; c < 50 && m_phase != 3; c++) step();
        rate_sel = 2'd0;
        step();
        check_eq("chg_tick0", 32'(tk0), 0);
        step();
        check_eq("chg_tick1", 32'(tk0), 0);
        step();
        check_eq("chg_tick2", 32'(tk0), 1);

        // Random traffic with occasional rate changes and resets
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 249) == 0);
            set_btn(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 39) == 0) rate_sel = 2'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
